// File: rtl/dec_key_encoder_if.sv
// Key-encoder bus: raw key lines in, encoded key code out over a valid/ready handshake.
interface dec_key_encoder_if #(
  parameter int N_IN   = 10,
  parameter int CODE_W = 4
);
  // Handshake: the master raises code_valid with code_out/multi_hot stable and holds all three
  // unchanged until an edge where code_valid && code_ready; that edge is the single transfer.
  logic [N_IN-1:0]   key_in;
  logic [CODE_W-1:0] code_out;
  logic              code_valid;
  logic              code_ready;
  logic              multi_hot;

  modport master (
    input  key_in,
    input  code_ready,
    output code_out,
    output code_valid,
    output multi_hot
  );

  modport slave (
    output key_in,
    output code_ready,
    input  code_out,
    input  code_valid,
    input  multi_hot
  );
endinterface

// File: rtl/dec_key_encoder.sv
// Debounced priority key encoder: registers raw keys, debounces, encodes the stable key,
// presents it over valid/ready, then waits for release with optional typematic repeat.
module dec_key_encoder #(
  parameter int N_IN          = 10,
  parameter int CODE_W        = 4,
  parameter int DEBOUNCE      = 4,
  parameter bit PRIORITY_HIGH = 1'b1,
  parameter int REPEAT_DLY    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_key_encoder_if.master    bus,
  output logic [1:0]           dbg_state_o
);

  localparam int CNT_MAX = (DEBOUNCE > REPEAT_DLY) ? DEBOUNCE : REPEAT_DLY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DB_C  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] RD_C  = CNT_W'(REPEAT_DLY);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESENT  = 2'd2,
    S_HELD     = 2'd3
  } state_e;

  state_e            state_q;
  logic [N_IN-1:0]   key_q;
  logic [N_IN-1:0]   cand_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  rcnt_q;
  logic [CNT_W-1:0]  hcnt_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              multi_q;

  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  rcnt_d;
  logic [CNT_W-1:0]  hcnt_d;
  logic [CODE_W-1:0] enc_idx;
  logic              enc_multi;

  assign cnt_d  = cnt_q + ONE_C;
  assign rcnt_d = rcnt_q + ONE_C;
  assign hcnt_d = hcnt_q + ONE_C;

  // Later loop iterations overwrite earlier ones, so scan direction picks the winning key.
  always_comb begin
    enc_idx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < N_IN; i++) begin
        if (cand_q[i]) enc_idx = CODE_W'(i);
      end
    end else begin
      for (int i = N_IN - 1; i >= 0; i--) begin
        if (cand_q[i]) enc_idx = CODE_W'(i);
      end
    end
  end

  assign enc_multi = ($countones(cand_q) > 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      hcnt_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      key_q <= bus.key_in;
      case (state_q)
        S_IDLE: begin
          if (key_q != '0) begin
            cand_q  <= key_q;
            cnt_q   <= ONE_C;
            state_q <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (key_q == '0) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (key_q != cand_q) begin
            cand_q <= key_q;
            cnt_q  <= ONE_C;
          end else if (cnt_q == DB_C) begin
            code_q  <= enc_idx;
            multi_q <= enc_multi;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_PRESENT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_PRESENT: begin
          // Outputs stay frozen here; only the consumer's acceptance moves us on.
          if (bus.code_ready) begin
            valid_q <= 1'b0;
            rcnt_q  <= '0;
            hcnt_q  <= '0;
            state_q <= S_HELD;
          end
        end
        S_HELD: begin
          if (key_q == '0) begin
            hcnt_q <= '0;
            if (rcnt_d == DB_C) begin
              rcnt_q  <= '0;
              state_q <= S_IDLE;
            end else begin
              rcnt_q <= rcnt_d;
            end
          end else begin
            rcnt_q <= '0;
            // Other keys only reset the repeat timer; a new key needs a full release first.
            if (REPEAT_DLY > 0 && key_q == cand_q) begin
              if (hcnt_d == RD_C) begin
                hcnt_q  <= '0;
                valid_q <= 1'b1;
                state_q <= S_PRESENT;
              end else begin
                hcnt_q <= hcnt_d;
              end
            end else begin
              hcnt_q <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.code_out   = code_q;
  assign bus.code_valid = valid_q;
  assign bus.multi_hot  = multi_q;
  assign dbg_state_o    = state_q;

endmodule

// File: doc/dec_key_encoder.md
Name: dec_key_encoder

Overview:
- Parametrised, clocked successor to the combinational decimal-to-BCD encoder.
- Takes N_IN key/request lines and debounces them.
- Priority-encodes the stable key into a binary code, presented through a valid/ready handshake.
- Flags multi-key presses and optionally re-issues a held key (typematic repeat).
- Sits between raw switch/keypad inputs and downstream BCD/display logic.

Parameters:
- N_IN, 10, number of key input lines (>=2).
- CODE_W, 4, code output width; must be >= clog2(N_IN).
- DEBOUNCE, 4, consecutive identical samples required to accept a press or release (>=1).
- PRIORITY_HIGH, 1, 1 = highest set index wins; 0 = lowest set index wins.
- REPEAT_DLY, 0, cycles a key must stay held before the code is re-issued; 0 disables repeat.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- key_in  input  N_IN  raw key lines, active high, bit i = key i.
- code_out  output  CODE_W  index of the winning key; stable while code_valid is high.
- code_valid  output  1  a code is presented.
- code_ready  input  1  consumer accepts the code when high together with code_valid.
- multi_hot  output  1  more than one bit was set in the accepted snapshot; qualified by code_valid.

Behaviour:
- Reset: when rst_n is low at a clock edge, the following are cleared after that edge:
  - state = IDLE
  - key_q, cand, and all counters = 0
  - code_out = 0, code_valid = 0, multi_hot = 0
- Reset applies mid-operation, including mid-handshake; a pending code is discarded.
- Input stage: key_q registers key_in every cycle. All decisions use key_q only.
- IDLE:
  - key_q != 0: cand <= key_q, cnt <= 1, go to DEBOUNCE.
- DEBOUNCE:
  - key_q == 0: return to IDLE.
  - key_q != cand and nonzero: cand <= key_q, cnt <= 1.
  - key_q == cand with cnt == DEBOUNCE: load code_out and multi_hot, set code_valid = 1, go to PRESENT.
  - Otherwise: cnt++.
  - Net effect: code_valid rises DEBOUNCE edges after key_q first holds the final value.
  - With DEBOUNCE=4 and key_in changed before edge 0, code_valid is high after edge 5.
- Encoding:
  - code_out = index of the highest set bit of cand (PRIORITY_HIGH=1) or the lowest set bit (PRIORITY_HIGH=0), zero-extended to CODE_W.
  - Key 0 yields code 0 with code_valid=1; a pressed key 0 is distinct from "no key".
- multi_hot = popcount(cand) > 1, captured at the same edge as code_out.
- PRESENT:
  - code_out, multi_hot and code_valid are held unchanged regardless of key_in.
  - On an edge with code_valid && code_ready: code_valid <= 0, rcnt <= 0, go to HELD.
  - If code_ready is already high in the cycle code_valid rises, code_valid is high for exactly one cycle.
- HELD (waits for release):
  - key_q == 0: rcnt++. At rcnt == DEBOUNCE go to IDLE.
  - key_q != 0: rcnt <= 0. Keys other than cand are ignored; a new key requires a full release first.
  - Repeat (REPEAT_DLY > 0): a hold counter counts cycles with key_q == cand.
    - Any other value clears the counter.
    - At count == REPEAT_DLY: re-present the same code_out and multi_hot with code_valid=1, go to PRESENT, hold counter cleared.
  - REPEAT_DLY = 0: no re-issue ever.
- Counter widths: clog2(max(DEBOUNCE, REPEAT_DLY)+1). Counters must not wrap; they saturate at the compare value.
- The block never drops a presented code: no new event is produced while in PRESENT.

Test Plan:
- Defaults; key_in=10'b01_0000_0000 (key 8) held 20 cycles; code_ready=1 -> code_valid high for exactly one cycle, 5 edges after key_in changes; code_out=4'd8, multi_hot=0.
- key_in toggles 0/key 3 every 2 cycles for 12 cycles, then holds key 3 -> no code_valid during toggling; one pulse with code_out=3 after the stable hold.
- key_in = keys 2 and 9 held; PRIORITY_HIGH=1 -> code_out=9, multi_hot=1. Rerun with PRIORITY_HIGH=0 -> code_out=2, multi_hot=1.
- Key 5 accepted with code_ready=0 for 10 cycles, key_in changed to key 1 meanwhile -> code_out stays 5 and code_valid stays high until code_ready rises. Key 1 is not reported until all keys are released for 4 cycles and key 1 is pressed again.
- REPEAT_DLY=8; key 0 held 40 cycles, code_ready=1 -> first pulse code_out=0, then further pulses spaced 9 cycles apart (8-cycle hold + handshake cycle), all code 0.
- rst_n=0 for one edge while code_valid=1 -> after that edge code_valid=0, code_out=0, multi_hot=0. With key 4 still held after reset, a fresh debounce produces code_out=4.
